// File: rtl/solver_pkg.sv
// Shared definitions for the solver datapath cells and sequencing controllers.
// Holds the common candidate-value width default and the state encoding used
// by the min-bound scan controller so that other cells agree on it.
package solver_pkg;

   // Default width of signed candidate values across the min/max cells.
   localparam int DEFAULT_NUMBER_SIZE = 4;

   // Scan controller states. The encoding is fixed so that debug taps and
   // neighbouring blocks can decode the state directly.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_e;

endpackage

// File: rtl/min_act_cell.sv
// Minimum-with-activation cell.
// Selects the smaller of two signed operands while respecting activation:
// an inactive operand only wins when the other one cannot (see rule below).
// Ports:
//   a_i / a_act_i   first operand and its activation flag (accumulator side)
//   b_i / b_act_i   second operand and its activation flag (new term side)
//   min_o           selected value
//   act_o           OR of both activation flags
module min_act_cell #(
   parameter int W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic         a_act_i,
   input  logic [W-1:0] b_i,
   input  logic         b_act_i,
   output logic [W-1:0] min_o,
   output logic         act_o
);

   // When a is not larger it wins only if active; when a is larger, b wins
   // only if active. On equal active operands a wins, which keeps earlier
   // accumulated terms ahead of later ones.
   always_comb begin
      min_o = b_i;
      if ($signed(a_i) <= $signed(b_i)) begin
         if (a_act_i) begin
            min_o = a_i;
         end
      end else if (!b_act_i) begin
         min_o = a_i;
      end
      act_o = a_act_i | b_act_i;
   end

endmodule

// File: rtl/min_bound_scan_controller_merge.sv
// Combinational merge stage of the min-bound scan controller.
// Folds one candidate term into the running accumulator using the shared
// min cell, and tracks which term index the selected value came from.
// Ports:
//   accValue_i / accAct_i / accIdx_i      current accumulator
//   termValue_i / termActive_i / termIdx_i candidate being merged
//   mergedValue_o / mergedAct_o / mergedIdx_o  accumulator after merging
module min_bound_scan_controller_merge #(
   parameter int NUMBER_SIZE = 4,
   parameter int INDEX_WIDTH = 3
) (
   input  logic [NUMBER_SIZE-1:0] accValue_i,
   input  logic                   accAct_i,
   input  logic [INDEX_WIDTH-1:0] accIdx_i,
   input  logic [NUMBER_SIZE-1:0] termValue_i,
   input  logic                   termActive_i,
   input  logic [INDEX_WIDTH-1:0] termIdx_i,
   output logic [NUMBER_SIZE-1:0] mergedValue_o,
   output logic                   mergedAct_o,
   output logic [INDEX_WIDTH-1:0] mergedIdx_o
);

   logic keepAcc;

   min_act_cell #(
      .W(NUMBER_SIZE)
   ) u_minCell (
      .a_i    (accValue_i),
      .a_act_i(accAct_i),
      .b_i    (termValue_i),
      .b_act_i(termActive_i),
      .min_o  (mergedValue_o),
      .act_o  (mergedAct_o)
   );

   // The min cell only reports a value, so the index is chosen by repeating
   // its selection decision here. Ties between active operands keep the
   // accumulator, so the lowest index wins.
   always_comb begin
      if ($signed(accValue_i) <= $signed(termValue_i)) begin
         keepAcc = accAct_i;
      end else begin
         keepAcc = !termActive_i;
      end
      mergedIdx_o = keepAcc ? accIdx_i : termIdx_i;
   end

endmodule

// File: rtl/min_bound_scan_controller.sv
// Min-bound scan controller.
// Walks a frame of NUM_TERMS candidate bounds from an external
// combinational-read table, one term per cycle, folding each into a shared
// signed minimum accumulator. Reports the frame minimum, whether any term
// was active, and the index of the winning term, with a one-cycle done pulse.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, abort        begin a scan (IDLE only) / cancel back to IDLE
//   term_index          table read address
//   term_value          signed candidate at term_index
//   term_active         candidate participates in the compare
//   busy, done          scan in progress / result-valid pulse
//   minimum             frame minimum, held until the next start
//   minimum_activation  at least one candidate was active
//   min_index           index of the term that produced minimum
module min_bound_scan_controller
   import solver_pkg::*;
#(
   parameter int NUMBER_SIZE = DEFAULT_NUMBER_SIZE,
   parameter int NUM_TERMS   = 8,
   parameter int INDEX_WIDTH = $clog2(NUM_TERMS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   output logic [INDEX_WIDTH-1:0] term_index,
   input  logic [NUMBER_SIZE-1:0] term_value,
   input  logic                   term_active,
   output logic                   busy,
   output logic                   done,
   output logic [NUMBER_SIZE-1:0] minimum,
   output logic                   minimum_activation,
   output logic [INDEX_WIDTH-1:0] min_index
);

   localparam logic [INDEX_WIDTH-1:0] LastIdx = INDEX_WIDTH'(NUM_TERMS - 1);

   scan_state_e            state_q, state_d;
   logic [INDEX_WIDTH-1:0] termIndex_q, termIndex_d;
   logic [NUMBER_SIZE-1:0] accValue_q, accValue_d;
   logic                   accAct_q, accAct_d;
   logic [INDEX_WIDTH-1:0] accIdx_q, accIdx_d;
   logic [NUMBER_SIZE-1:0] minimum_q, minimum_d;
   logic                   minAct_q, minAct_d;
   logic [INDEX_WIDTH-1:0] minIdx_q, minIdx_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic [NUMBER_SIZE-1:0] mergedValue;
   logic                   mergedAct;
   logic [INDEX_WIDTH-1:0] mergedIdx;

   min_bound_scan_controller_merge #(
      .NUMBER_SIZE(NUMBER_SIZE),
      .INDEX_WIDTH(INDEX_WIDTH)
   ) u_merge (
      .accValue_i   (accValue_q),
      .accAct_i     (accAct_q),
      .accIdx_i     (accIdx_q),
      .termValue_i  (term_value),
      .termActive_i (term_active),
      .termIdx_i    (termIndex_q),
      .mergedValue_o(mergedValue),
      .mergedAct_o  (mergedAct),
      .mergedIdx_o  (mergedIdx)
   );

   // Next-state logic. Abort overrides everything and returns to IDLE without
   // touching the published result. busy is registered from the next state so
   // it covers the whole scan plus the cycle in which done is visible.
   always_comb begin
      state_d     = state_q;
      termIndex_d = termIndex_q;
      accValue_d  = accValue_q;
      accAct_d    = accAct_q;
      accIdx_d    = accIdx_q;
      minimum_d   = minimum_q;
      minAct_d    = minAct_q;
      minIdx_d    = minIdx_q;
      done_d      = 1'b0;

      if (abort) begin
         state_d     = IDLE;
         termIndex_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d     = SCAN;
                  termIndex_d = '0;
                  accValue_d  = '0;
                  accAct_d    = 1'b0;
                  accIdx_d    = '0;
               end
            end
            SCAN: begin
               accValue_d = mergedValue;
               accAct_d   = mergedAct;
               accIdx_d   = mergedIdx;
               if (termIndex_q == LastIdx) begin
                  state_d     = DONE;
                  termIndex_d = '0;
               end else begin
                  termIndex_d = termIndex_q + 1'b1;
               end
            end
            DONE: begin
               minimum_d = accValue_q;
               minAct_d  = accAct_q;
               minIdx_d  = accIdx_q;
               done_d    = 1'b1;
               state_d   = IDLE;
            end
            default: begin
               state_d     = IDLE;
               termIndex_d = '0;
            end
         endcase
      end

      busy_d = (state_d != IDLE) || done_d;
   end

   // All state, including the published outputs, clears asynchronously so a
   // reset mid-scan is visible on the outputs immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         termIndex_q <= '0;
         accValue_q  <= '0;
         accAct_q    <= 1'b0;
         accIdx_q    <= '0;
         minimum_q   <= '0;
         minAct_q    <= 1'b0;
         minIdx_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         termIndex_q <= termIndex_d;
         accValue_q  <= accValue_d;
         accAct_q    <= accAct_d;
         accIdx_q    <= accIdx_d;
         minimum_q   <= minimum_d;
         minAct_q    <= minAct_d;
         minIdx_q    <= minIdx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign term_index         = termIndex_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign minimum            = minimum_q;
   assign minimum_activation = minAct_q;
   assign min_index          = minIdx_q;

endmodule

// File: tb/tb_min_bound_scan_controller.sv
// Self-checking bench for min_bound_scan_controller with the default
// 8-term, 4-bit configuration. The candidate table is a bench array read
// combinationally at term_index; expected results come from a plain
// "smallest active value, earliest index" model.
module tb_min_bound_scan_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic [2:0] term_index;
   logic [3:0] term_value;
   logic       term_active;
   logic       busy;
   logic       done;
   logic [3:0] minimum;
   logic       minimum_activation;
   logic [2:0] min_index;

   logic [3:0] tabValue [8];
   logic       tabActive [8];

   int checks   = 0;
   int failures = 0;

   assign term_value  = tabValue[term_index];
   assign term_active = tabActive[term_index];

   min_bound_scan_controller dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .abort             (abort),
      .term_index        (term_index),
      .term_value        (term_value),
      .term_active       (term_active),
      .busy              (busy),
      .done              (done),
      .minimum           (minimum),
      .minimum_activation(minimum_activation),
      .min_index         (min_index)
   );

   always #5 clk = ~clk;

   // Term i occupies nibble i of vals; bit i of mask is its activation.
   task automatic setTable(input logic [31:0] vals, input logic [7:0] mask);
      for (int i = 0; i < 8; i++) begin
         tabValue[i]  = vals[4*i +: 4];
         tabActive[i] = mask[i];
      end
   endtask

   task automatic randomTable();
      for (int i = 0; i < 8; i++) begin
         tabValue[i]  = 4'($urandom_range(0, 15));
         tabActive[i] = ($urandom_range(0, 3) != 0);
      end
   endtask

   // Reference: smallest signed value among active terms, earliest on ties.
   function automatic void modelFrame(output logic [3:0] expMin, output int expIdx,
                                      output logic expAct);
      expMin = '0;
      expIdx = 0;
      expAct = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (tabActive[i] && (!expAct || $signed(tabValue[i]) < $signed(expMin))) begin
            expMin = tabValue[i];
            expIdx = i;
            expAct = 1'b1;
         end
      end
   endfunction

   // Issue one start and return at the negedge of the cycle in which done is
   // seen; doneCycle counts cycles after the start edge, -1 on timeout.
   task automatic runFrame(output int doneCycle);
      doneCycle = -1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            doneCycle = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      setTable(32'h0, 8'h00);
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", done); end
      checks++; if (minimum !== 4'd0) begin failures++; $display("[TB] FAIL reset_minimum got=%0d want=0", $signed(minimum)); end
      checks++; if (minimum_activation !== 1'b0) begin failures++; $display("[TB] FAIL reset_act got=%b want=0", minimum_activation); end
      checks++; if (min_index !== 3'd0) begin failures++; $display("[TB] FAIL reset_min_index got=%0d want=0", min_index); end
      checks++; if (term_index !== 3'd0) begin failures++; $display("[TB] FAIL reset_term_index got=%0d want=0", term_index); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_all_active();
      int dc;
      setTable(32'hF71085E3, 8'hFF);
      runFrame(dc);
      checks++; if (dc !== 10) begin failures++; $display("[TB] FAIL all_active_latency got=%0d want=10", dc); end
      checks++; if (minimum !== 4'h8) begin failures++; $display("[TB] FAIL all_active_min got=%0d want=-8", $signed(minimum)); end
      checks++; if (min_index !== 3'd3) begin failures++; $display("[TB] FAIL all_active_idx got=%0d want=3", min_index); end
      checks++; if (minimum_activation !== 1'b1) begin failures++; $display("[TB] FAIL all_active_act got=%b want=1", minimum_activation); end
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL all_active_busy_at_done got=%b want=1", busy); end
      @(negedge clk);
   endtask

   task automatic test_masked();
      int dc;
      setTable(32'hF71085E3, 8'hF7);
      runFrame(dc);
      checks++; if (dc !== 10) begin failures++; $display("[TB] FAIL masked_latency got=%0d want=10", dc); end
      checks++; if (minimum !== 4'hE) begin failures++; $display("[TB] FAIL masked_min got=%0d want=-2", $signed(minimum)); end
      checks++; if (min_index !== 3'd1) begin failures++; $display("[TB] FAIL masked_idx got=%0d want=1", min_index); end
      checks++; if (minimum_activation !== 1'b1) begin failures++; $display("[TB] FAIL masked_act got=%b want=1", minimum_activation); end
      @(negedge clk);
   endtask

   task automatic test_all_inactive();
      int dc;
      setTable(32'hF71085E3, 8'h00);
      runFrame(dc);
      checks++; if (dc !== 10) begin failures++; $display("[TB] FAIL inactive_latency got=%0d want=10", dc); end
      checks++; if (minimum_activation !== 1'b0) begin failures++; $display("[TB] FAIL inactive_act got=%b want=0", minimum_activation); end
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL inactive_busy_at_done got=%b want=1", busy); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL inactive_done_width got=%b want=0", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL inactive_busy_fall got=%b want=0", busy); end
   endtask

   task automatic test_ties();
      int dc;
      setTable(32'h522D6DD4, 8'hFF);
      runFrame(dc);
      checks++; if (dc !== 10) begin failures++; $display("[TB] FAIL ties_latency got=%0d want=10", dc); end
      checks++; if (minimum !== 4'hD) begin failures++; $display("[TB] FAIL ties_min got=%0d want=-3", $signed(minimum)); end
      checks++; if (min_index !== 3'd1) begin failures++; $display("[TB] FAIL ties_idx got=%0d want=1", min_index); end
      @(negedge clk);
   endtask

   // Expects the result of test_ties (-3 at index 1) to be the published one.
   task automatic test_abort();
      int dc;
      int doneSeen;
      logic [3:0] expMin;
      int expIdx;
      logic expAct;
      doneSeen = 0;
      setTable(32'hF71085E3, 8'hFF);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (done === 1'b1) doneSeen++;
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got=%b want=0", busy); end
      checks++; if (term_index !== 3'd0) begin failures++; $display("[TB] FAIL abort_term_index got=%0d want=0", term_index); end
      for (int k = 0; k < 15; k++) begin
         if (done === 1'b1) doneSeen++;
         @(negedge clk);
      end
      checks++; if (doneSeen !== 0) begin failures++; $display("[TB] FAIL abort_no_done got=%0d pulses want=0", doneSeen); end
      checks++; if (minimum !== 4'hD || min_index !== 3'd1 || minimum_activation !== 1'b1) begin
         failures++;
         $display("[TB] FAIL abort_result_held got=%0d/%0d/%b want=-3/1/1", $signed(minimum), min_index, minimum_activation);
      end
      // abort wins over a simultaneous start
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_over_start got=%b want=0", busy); end
      randomTable();
      tabActive[5] = 1'b1;
      modelFrame(expMin, expIdx, expAct);
      runFrame(dc);
      checks++; if (dc !== 10) begin failures++; $display("[TB] FAIL abort_restart_latency got=%0d want=10", dc); end
      checks++; if (minimum !== expMin || min_index !== 3'(expIdx)) begin
         failures++;
         $display("[TB] FAIL abort_restart_result got=%0d/%0d want=%0d/%0d", $signed(minimum), min_index, $signed(expMin), expIdx);
      end
      @(negedge clk);
   endtask

   task automatic test_start_held();
      int pulses;
      int firstAt;
      int secondAt;
      int idleSeen;
      pulses = 0;
      firstAt = -1;
      secondAt = -1;
      idleSeen = 0;
      setTable(32'h522D6DD4, 8'hFE);
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            pulses++;
            if (pulses == 1) firstAt = k;
            if (pulses == 2) secondAt = k;
         end
      end
      start = 1'b0;
      checks++; if (pulses !== 2) begin failures++; $display("[TB] FAIL held_pulse_count got=%0d want=2", pulses); end
      checks++; if (firstAt !== 10 || secondAt !== 20) begin
         failures++;
         $display("[TB] FAIL held_pulse_timing got=%0d,%0d want=10,20", firstAt, secondAt);
      end
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (busy === 1'b0 && done === 1'b0) begin
            idleSeen = 1;
            break;
         end
      end
      checks++; if (idleSeen !== 1) begin failures++; $display("[TB] FAIL held_return_idle got=%0d want=1", idleSeen); end
      checks++; if (minimum !== 4'hD || min_index !== 3'd1) begin
         failures++;
         $display("[TB] FAIL held_result got=%0d/%0d want=-3/1", $signed(minimum), min_index);
      end
   endtask

   task automatic test_start_ignored();
      int pulses;
      int firstAt;
      pulses = 0;
      firstAt = -1;
      setTable(32'hF71085E3, 8'hFF);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         start = (k == 4 || k == 9);
         if (done === 1'b1) begin
            pulses++;
            if (pulses == 1) firstAt = k;
         end
      end
      start = 1'b0;
      checks++; if (pulses !== 1 || firstAt !== 10) begin
         failures++;
         $display("[TB] FAIL ignored_start got=%0d pulses first=%0d want=1 pulse at 10", pulses, firstAt);
      end
   endtask

   task automatic test_extreme();
      int dc;
      setTable(32'h87777777, 8'h80);
      runFrame(dc);
      checks++; if (minimum !== 4'h8 || min_index !== 3'd7 || minimum_activation !== 1'b1) begin
         failures++;
         $display("[TB] FAIL extreme_result got=%0d/%0d/%b want=-8/7/1", $signed(minimum), min_index, minimum_activation);
      end
      @(negedge clk);
   endtask

   // Expects a non-zero published result from the previous frame.
   task automatic test_reset_mid_scan();
      setTable(32'hF71085E3, 8'hFF);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (term_index !== 3'd2) begin failures++; $display("[TB] FAIL midscan_term_index got=%0d want=2", term_index); end
      #2 reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || term_index !== 3'd0) begin
         failures++;
         $display("[TB] FAIL midscan_reset_ctrl got=busy%b done%b idx%0d want=0", busy, done, term_index);
      end
      checks++; if (minimum !== 4'd0 || min_index !== 3'd0 || minimum_activation !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midscan_reset_result got=%0d/%0d/%b want=0/0/0", $signed(minimum), min_index, minimum_activation);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Random frames issued back to back: each new start is raised in the
   // cycle where the previous done is visible.
   task automatic test_back_to_back();
      int dc;
      logic [3:0] expMin;
      int expIdx;
      logic expAct;
      for (int f = 0; f < 12; f++) begin
         randomTable();
         if (f == 5) begin
            for (int i = 0; i < 8; i++) tabActive[i] = 1'b0;
         end
         modelFrame(expMin, expIdx, expAct);
         runFrame(dc);
         checks++; if (dc !== 10) begin failures++; $display("[TB] FAIL b2b_latency frame=%0d got=%0d want=10", f, dc); end
         checks++; if (minimum_activation !== expAct) begin
            failures++;
            $display("[TB] FAIL b2b_act frame=%0d got=%b want=%b", f, minimum_activation, expAct);
         end
         if (expAct) begin
            checks++; if (minimum !== expMin || min_index !== 3'(expIdx)) begin
               failures++;
               $display("[TB] FAIL b2b_result frame=%0d got=%0d/%0d want=%0d/%0d", f, $signed(minimum), min_index, $signed(expMin), expIdx);
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      $display("[TB] starting min_bound_scan_controller bench");
      test_reset();
      test_all_active();
      test_masked();
      test_all_inactive();
      test_ties();
      test_abort();
      test_start_held();
      test_start_ignored();
      test_extreme();
      test_reset_mid_scan();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
